// File: rtl/fetch_align.sv
`default_nettype none
// ============================================================================
// Module   : fetch_align
// Purpose  : Instruction-fetch aligner. Buffers halfwords from word reads and
//            emits one aligned 32-bit or 16-bit instruction per cycle plus its
//            sequential next PC. Compressed (RVC) support via FETCH_ALIGN_RVC_EN.
// Revision : 1.0
// ============================================================================
module fetch_align #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              imem_en,
    output logic [ADDR_W-3:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              inst_is_c,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] c_INC_C    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_INC_W    = ADDR_W'(4);
    localparam logic [ADDR_W-3:0] c_FPTR_ONE = (ADDR_W-2)'(1);

    logic [ADDR_W-3:0] r_fptr;
    logic [ADDR_W-1:0] r_opc;
    logic [15:0]       r_q [4];
    logic [2:0]        r_count;
    logic              r_pending;
    logic              r_drop_lo;

    logic              w_head_c;
    logic              w_valid_raw;
    logic              w_pop;
    logic [2:0]        w_npop;
    logic [2:0]        w_cnt_after;
    logic [2:0]        w_cnt_next;
    logic [3:0]        w_demand;
    logic [15:0]       w_q_next [4];
    logic [ADDR_W-1:0] w_tgt_pc;
    logic              w_tgt_drop;
    logic              w_unused_pc_bits;

`ifdef FETCH_ALIGN_RVC_EN
    assign w_head_c   = (r_q[0][1:0] != 2'b11);
    assign w_tgt_pc   = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign w_tgt_drop = redirect_pc[1];
`else
    assign w_head_c   = 1'b0;
    assign w_tgt_pc   = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_tgt_drop = 1'b0;
`endif
    assign w_unused_pc_bits = ^redirect_pc[1:0];

    assign w_valid_raw = w_head_c ? (r_count != 3'd0) : (r_count >= 3'd2);
    assign inst_valid  = w_valid_raw && !redirect;
    assign inst_is_c   = w_valid_raw && w_head_c;
    assign inst        = w_head_c ? {16'h0000, r_q[0]} : {r_q[1], r_q[0]};
    assign inst_pc     = r_opc;
    assign next_pc     = r_opc + (inst_is_c ? c_INC_C : c_INC_W);
    assign imem_addr   = r_fptr;

    assign w_pop       = inst_valid && !stall;
    assign w_npop      = !w_pop ? 3'd0 : (w_head_c ? 3'd1 : 3'd2);
    assign w_cnt_after = r_count - w_npop;
    // Occupancy once the in-flight word lands must leave room for one more word.
    assign w_demand    = {1'b0, w_cnt_after} + {2'b00, r_pending, 1'b0};
    assign imem_en     = !rst && !redirect && (w_demand <= 4'd2);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_q_next[i] = r_q[i];
        end
        w_cnt_next = w_cnt_after;
        case (w_npop)
            3'd1: begin
                w_q_next[0] = r_q[1];
                w_q_next[1] = r_q[2];
                w_q_next[2] = r_q[3];
            end
            3'd2: begin
                w_q_next[0] = r_q[2];
                w_q_next[1] = r_q[3];
            end
            default: ;
        endcase
        if (r_pending) begin
            if (!r_drop_lo) begin
                w_q_next[w_cnt_next[1:0]] = imem_rdata[15:0];
                w_cnt_next                = w_cnt_next + 3'd1;
            end
            w_q_next[w_cnt_next[1:0]] = imem_rdata[31:16];
            w_cnt_next                = w_cnt_next + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fptr    <= '0;
            r_opc     <= '0;
            r_count   <= 3'd0;
            r_pending <= 1'b0;
            r_drop_lo <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 16'h0000;
            end
        end else if (redirect) begin
            // Any word returning next cycle belongs to the old stream and is dropped.
            r_count   <= 3'd0;
            r_pending <= 1'b0;
            r_fptr    <= redirect_pc[ADDR_W-1:2];
            r_opc     <= w_tgt_pc;
            r_drop_lo <= w_tgt_drop;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= w_q_next[i];
            end
            r_count   <= w_cnt_next;
            r_pending <= imem_en;
            if (r_pending) begin
                r_drop_lo <= 1'b0;
            end
            if (w_pop) begin
                r_opc <= next_pc;
            end
            if (imem_en) begin
                r_fptr <= r_fptr + c_FPTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_align
// Purpose  : Scoreboard bench for fetch_align; a reference instruction-stream
//            model fills the expected queue, a monitor checks accepted output.
// Revision : 1.0
// ============================================================================
module tb_fetch_align;

`ifdef FETCH_ALIGN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [11:0] pc;
        logic        is_c;
        logic [11:0] npc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        stall;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_is_c;
    logic [11:0] inst_pc;
    logic [11:0] next_pc;

    logic [31:0] mem [1024];
    exp_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;

    fetch_align #(.ADDR_W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_is_c   (inst_is_c),
        .inst_pc     (inst_pc),
        .next_pc     (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [11:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [11:0] start_of(input logic [11:0] tgt);
        return RVC ? {tgt[11:1], 1'b0} : {tgt[11:2], 2'b00};
    endfunction

    function automatic int exp_latency(input logic [11:0] start);
        return (RVC && start[1] && hw_at(start)[1:0] == 2'b11) ? 4 : 3;
    endfunction

    // Walk the instruction stream from memory: the halfword at pc decides length.
    function automatic void push_stream(input logic [11:0] start, input int n);
        logic [11:0] pc;
        logic [15:0] h;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            h = hw_at(pc);
            if (RVC && h[1:0] != 2'b11) begin
                e.inst = {16'h0000, h};
                e.is_c = 1'b1;
                e.npc  = pc + 12'd2;
            end else begin
                e.inst = {hw_at(pc + 12'd2), h};
                e.is_c = 1'b0;
                e.npc  = pc + 12'd4;
            end
            e.pc = pc;
            exp_q.push_back(e);
            pc = e.npc;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && inst_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_inst", {20'h0, inst_pc, inst}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("inst", {7'h0, inst, inst_pc, inst_is_c, next_pc}, {7'h0, e});
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1; redirect = 1'b0; stall = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_inst", inst, 0);
            chk("rst_valid", inst_valid, 0);
            chk("rst_is_c", inst_is_c, 0);
            chk("rst_pc", inst_pc, 0);
            chk("rst_next_pc", next_pc, 12'h004);
            chk("rst_imem_en", imem_en, 0);
            chk("rst_imem_addr", imem_addr, 0);
        end
        rst = 1'b0;
        push_stream(12'h000, n);
    endtask

    task automatic do_redirect(input logic [11:0] tgt, input bit st, input int n);
        redirect = 1'b1; redirect_pc = tgt; stall = st;
        exp_q.delete();
        @(negedge clk);
        chk("redir_valid", inst_valid, 0);
        @(posedge clk); #1;
        redirect = 1'b0;
        push_stream(start_of(tgt), n);
    endtask

    task automatic run_seg(input int n, input int lat, input logic [9:0] addr,
                           input bit hold, input bit tput, input int pct);
        int          cyc;
        int          hold_cnt;
        bit          seen;
        bit          in_hold;
        logic [31:0] h_inst;
        logic [11:0] h_pc;
        cyc = 1; hold_cnt = 0; seen = 0; h_inst = '0; h_pc = '0;
        while (exp_q.size() > 0 && cyc < 400) begin
            in_hold = 0;
            if (hold && seen && hold_cnt < 3) begin
                stall = 1'b1; hold_cnt++; in_hold = 1;
            end else begin
                stall = ($urandom_range(99) < pct);
            end
            @(negedge clk);
            if (cyc == 1) begin
                chk("issue_en", imem_en, 1);
                chk("issue_addr", imem_addr, addr);
            end
            if (!seen && inst_valid) begin
                seen = 1;
                chk("latency", cyc, lat);
            end
            if (in_hold) begin
                if (hold_cnt == 1) begin
                    chk("hold_valid", inst_valid, 1);
                    h_inst = inst; h_pc = inst_pc;
                end else begin
                    chk("hold_inst", inst, h_inst);
                    chk("hold_pc", inst_pc, h_pc);
                    chk("hold_imem_en", imem_en, 0);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("seg_drained", exp_q.size(), 0);
        if (tput) chk("throughput", cyc, lat + n);
        stall = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic [11:0] tgt;
        int          n;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if ($urandom_range(1) == 1) w[1:0] = 2'b11;
            if ($urandom_range(1) == 1) w[17:16] = 2'b11;
            mem[i] = w;
        end
        mem[0] = 32'h0000_0013;
        mem[10'h010] = 32'h0010_0093;
        mem[10'h011] = 32'h0020_0113;
        mem[10'h012] = 32'h0030_0193;
        for (int i = 3; i < 16; i++) mem[10'h010 + i] = $urandom | 32'h3;
        mem[10'h040] = 32'h0093_0001;
        mem[10'h041] = 32'h4505_0000;
        mem[10'h080] = 32'h1233_0001;
        mem[10'h3FF] = 32'h00A0_0093;

        do_reset(8);
        run_seg(8, 3, 10'h000, 0, 0, 20);

        do_redirect(12'h040, 0, 12);
        run_seg(12, 3, 10'h010, 0, 1, 0);

        do_redirect(12'h040, 0, 12);
        run_seg(12, 3, 10'h010, 1, 0, 25);

        do_redirect(12'h100, 0, 10);
        run_seg(10, exp_latency(start_of(12'h100)), 10'h040, 0, 0, 30);

        do_redirect(12'h0A6, 1, 10);
        run_seg(10, exp_latency(start_of(12'h0A6)), 10'h029, 0, 0, 30);

        do_redirect(12'hFFC, 0, 6);
        run_seg(6, 3, 10'h3FF, 0, 0, 20);

        do_redirect(12'h202, 0, 8);
        run_seg(8, exp_latency(start_of(12'h202)), 10'h080, 0, 0, 30);

        for (int s = 0; s < 8; s++) begin
            tgt = 12'($urandom_range(0, 2047) * 2);
            n   = $urandom_range(5, 25);
            do_redirect(tgt, 1'($urandom_range(1)), n);
            run_seg(n, exp_latency(start_of(tgt)), tgt[11:2], 0, 0, 40);
        end

        do_reset(10);
        run_seg(10, 3, 10'h000, 0, 0, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
